// File: rtl/alu_result_disp.sv
// alu_result_disp: consumer side of the 4-bit ALU result interface.
// Captures each result (res/car/of) with its opcode on a valid/ready
// handshake and scans it onto a shared active-low 4-digit 7-segment bus.
// Digit 0 = magnitude, digit 1 = sign, digit 2 = flags, digit 3 = opcode.
module alu_result_disp #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] res,
    input  logic       car,
    input  logic       of,
    input  logic [2:0] ctrl,
    input  logic       res_valid,
    input  logic       freeze,
    output logic       res_ready,
    output logic [3:0] an,
    output logic [7:0] seg_out
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    // Segment patterns {dp,g,f,e,d,c,b,a}, active-low.
    function automatic logic [7:0] f_glyph(input logic [3:0] v);
        logic [7:0] g;
        case (v)
            4'h0:    g = 8'hC0;
            4'h1:    g = 8'hF9;
            4'h2:    g = 8'hA4;
            4'h3:    g = 8'hB0;
            4'h4:    g = 8'h99;
            4'h5:    g = 8'h92;
            4'h6:    g = 8'h82;
            4'h7:    g = 8'hF8;
            4'h8:    g = 8'h80;
            4'h9:    g = 8'h90;
            4'hA:    g = 8'h88;
            4'hB:    g = 8'h83;
            4'hC:    g = 8'hC6;
            4'hD:    g = 8'hA1;
            4'hE:    g = 8'h86;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    logic [3:0]    r_res;
    logic          r_car;
    logic          r_of;
    logic [2:0]    r_ctrl;
    logic          r_have_data;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic [3:0]    r_an;
    logic [7:0]    r_seg;

    logic          w_accept;
    logic [3:0]    w_res_cap;
    logic          w_car_cap;
    logic          w_of_cap;
    logic [2:0]    w_ctrl_cap;
    logic          w_have_cap;
    logic          w_signed;
    logic [3:0]    w_mag;
    logic          w_wrap;
    logic [7:0]    w_digit [4];
    logic [7:0]    w_seg_sel [4];

    assign res_ready = ~freeze;
    assign w_accept  = res_valid & ~freeze;

    // Data as it will be after this edge, so a digit registered on the
    // capture edge already reflects the newly accepted result.
    assign w_res_cap  = w_accept ? res  : r_res;
    assign w_car_cap  = w_accept ? car  : r_car;
    assign w_of_cap   = w_accept ? of   : r_of;
    assign w_ctrl_cap = w_accept ? ctrl : r_ctrl;
    assign w_have_cap = r_have_data | w_accept;

    // Opcodes 000/001 produce two's-complement results; 4'b1000 maps to 8.
    assign w_signed = (w_ctrl_cap[2:1] == 2'b00);
    assign w_mag    = w_res_cap[3] ? (~w_res_cap + 4'd1) : w_res_cap;

    assign w_digit[0] = w_signed ? f_glyph(w_mag) : f_glyph(w_res_cap);
    assign w_digit[1] = (w_signed && w_res_cap[3]) ? 8'hBF : 8'hFF;
    assign w_digit[2] = (w_car_cap ? 8'hC6 : 8'hFF) & (w_of_cap ? 8'h7F : 8'hFF);
    assign w_digit[3] = f_glyph({1'b0, w_ctrl_cap});

    // Every digit blanks until a first result has been accepted.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_blank
            assign w_seg_sel[gi] = w_have_cap ? w_digit[gi] : 8'hFF;
        end
    endgenerate

    assign w_wrap = (r_cnt == CNT_LAST);

    // Capture registers: load on handshake, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res       <= 4'd0;
            r_car       <= 1'b0;
            r_of        <= 1'b0;
            r_ctrl      <= 3'd0;
            r_have_data <= 1'b0;
        end else if (w_accept) begin
            r_res       <= res;
            r_car       <= car;
            r_of        <= of;
            r_ctrl      <= ctrl;
            r_have_data <= 1'b1;
        end
    end

    // Scan timing: dwell counter and digit index, independent of freeze.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Registered display outputs driven from the current digit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 4'b1111;
            r_seg <= 8'hFF;
        end else begin
            r_an  <= ~(4'b0001 << r_idx);
            r_seg <= w_seg_sel[r_idx];
        end
    end

    assign an      = r_an;
    assign seg_out = r_seg;

endmodule

// File: tb/tb_alu_result_disp.sv
// Testbench for alu_result_disp with a short scan period. Expected digit
// contents are queued when a result is driven and compared as each digit
// comes round on the scan.
module tb_alu_result_disp;

    localparam int SCAN_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [3:0] res;
    logic       car;
    logic       of;
    logic [2:0] ctrl;
    logic       res_valid;
    logic       freeze;
    logic       res_ready;
    logic [3:0] an;
    logic [7:0] seg_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      tag;
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t exp_q[$];

    alu_result_disp #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .res       (res),
        .car       (car),
        .of        (of),
        .ctrl      (ctrl),
        .res_valid (res_valid),
        .freeze    (freeze),
        .res_ready (res_ready),
        .an        (an),
        .seg_out   (seg_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    // Queue the four expected digit patterns of one displayed result.
    task automatic push_disp(input string tag, input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        exp_t e;
        e.tag = {tag, "_d0"}; e.an = 4'b1110; e.seg = d0; exp_q.push_back(e);
        e.tag = {tag, "_d1"}; e.an = 4'b1101; e.seg = d1; exp_q.push_back(e);
        e.tag = {tag, "_d2"}; e.an = 4'b1011; e.seg = d2; exp_q.push_back(e);
        e.tag = {tag, "_d3"}; e.an = 4'b0111; e.seg = d3; exp_q.push_back(e);
    endtask

    // Pop each expectation once its digit is enabled (bounded wait).
    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int n = 0; n < 40; n++) begin
                @(negedge clk);
                if (an == e.an) break;
            end
            chk({e.tag, "_an"}, 32'(an), 32'(e.an));
            chk({e.tag, "_seg"}, 32'(seg_out), 32'(e.seg));
        end
    endtask

    // Present one result for a single cycle.
    task automatic send(input logic [3:0] r, input logic c, input logic o, input logic [2:0] op);
        @(negedge clk);
        res = r; car = c; of = o; ctrl = op; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
    endtask

    initial begin
        logic [3:0] one;
        logic [3:0] exp_an;
        one = 4'b0001;
        rst_n = 1'b0; res = 4'd0; car = 1'b0; of = 1'b0; ctrl = 3'd0;
        res_valid = 1'b0; freeze = 1'b0;

        // Reset held for three cycles, then the blank scan sequence.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_an", 32'(an), 32'hF);
            chk("rst_seg", 32'(seg_out), 32'hFF);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            exp_an = ~(one << (((k - 1) / SCAN_DIV) % 4));
            chk($sformatf("scan%0d_an", k), 32'(an), 32'(exp_an));
            chk($sformatf("scan%0d_seg", k), 32'(seg_out), 32'hFF);
        end

        // Signed subtraction result -3 with carry.
        send(4'b1101, 1'b1, 1'b0, 3'b001);
        push_disp("sub", 8'hB0, 8'hBF, 8'hC6, 8'hF9);
        drain();

        // Most negative value with overflow: magnitude 8, dp lit.
        send(4'b1000, 1'b0, 1'b1, 3'b000);
        push_disp("ovf", 8'h80, 8'hBF, 8'h7F, 8'hC0);
        drain();

        // Logic op: hex glyph, never a sign.
        send(4'hA, 1'b0, 1'b0, 3'b101);
        push_disp("logic", 8'h88, 8'hFF, 8'hFF, 8'h92);
        drain();

        // Largest positive signed value.
        send(4'b0111, 1'b0, 1'b0, 3'b000);
        push_disp("pos7", 8'hF8, 8'hFF, 8'hFF, 8'hC0);
        drain();

        // Top opcode, both flags: C glyph with dp lit.
        send(4'hF, 1'b1, 1'b1, 3'b111);
        push_disp("flags", 8'h8E, 8'hFF, 8'h46, 8'hF8);
        drain();

        // Back-to-back valid cycles: last one wins.
        @(negedge clk);
        res = 4'h1; car = 1'b0; of = 1'b0; ctrl = 3'b110; res_valid = 1'b1;
        @(negedge clk);
        res = 4'hE; ctrl = 3'b010;
        @(negedge clk);
        res_valid = 1'b0;
        push_disp("b2b", 8'h86, 8'hFF, 8'hFF, 8'hA4);
        drain();

        // Freeze: new result refused, display held.
        send(4'h5, 1'b0, 1'b0, 3'b011);
        @(negedge clk);
        freeze = 1'b1; res = 4'h2; ctrl = 3'b000; res_valid = 1'b1;
        #1;
        chk("frz_ready", 32'(res_ready), 32'h0);
        push_disp("frz", 8'h92, 8'hFF, 8'hFF, 8'hB0);
        drain();
        @(negedge clk);
        freeze = 1'b0;
        #1;
        chk("unfrz_ready", 32'(res_ready), 32'h1);
        @(negedge clk);
        res_valid = 1'b0;
        push_disp("unfrz", 8'hA4, 8'hFF, 8'hFF, 8'hC0);
        drain();

        // Asynchronous reset while digit 2 is being shown.
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (an == 4'b1011) break;
        end
        chk("pre_arst_an", 32'(an), 32'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(an), 32'hF);
        chk("arst_seg", 32'(seg_out), 32'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        push_disp("post_rst", 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
